// File: rtl/reg_serial_tx.sv
// reg_serial_tx: parallel-to-serial transmitter for the register datapath.
// A WIDTH-bit word is loaded through an en/ready handshake. It is sent LSB
// first as a start bit (0), WIDTH data bits, an optional even-parity bit and
// a stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
// Optional feature macro: REG_SERIAL_TX_PARITY_EN. When it is defined, an
// even-parity bit is sent between the last data bit and the stop bit.
// All outputs are registered. The active-low reset is asynchronous.
module reg_serial_tx #(
    parameter int WIDTH        = 3,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             en,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [7:0]     CYC_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

`ifdef REG_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [BCW-1:0]   bit_cnt;
    logic [7:0]       bit_cyc;
    logic             cyc_last;
`ifdef REG_SERIAL_TX_PARITY_EN
    logic             par_bit;
`endif

    // Detect the final clock of the current bit, and form the next shifted word.
    // ser_out is registered, so the bit that follows a shift is taken from
    // shift_nxt rather than from the shift register itself.
    always_comb begin
        cyc_last  = (bit_cyc == CYC_LAST);
        shift_nxt = shift >> 1;
    end

    // Frame sequencer: handles the load handshake, the bit timing and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            bit_cyc <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            ser_out <= 1'b1;
            done    <= 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ser_out <= 1'b1;
                    if (en && ready) begin
                        shift   <= d_in;
                        bit_cnt <= '0;
                        bit_cyc <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        ser_out <= 1'b0;
                        state   <= START;
`ifdef REG_SERIAL_TX_PARITY_EN
                        par_bit <= ^d_in;
`endif
                    end
                end

                START: begin
                    if (cyc_last) begin
                        bit_cyc <= '0;
                        ser_out <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cyc <= bit_cyc + 8'd1;
                    end
                end

                DATA: begin
                    if (cyc_last) begin
                        bit_cyc <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef REG_SERIAL_TX_PARITY_EN
                            ser_out <= par_bit;
                            state   <= PARITY;
`else
                            ser_out <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            shift   <= shift_nxt;
                            ser_out <= shift_nxt[0];
                        end
                    end else begin
                        bit_cyc <= bit_cyc + 8'd1;
                    end
                end

`ifdef REG_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (cyc_last) begin
                        bit_cyc <= '0;
                        ser_out <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cyc <= bit_cyc + 8'd1;
                    end
                end
`endif

                STOP: begin
                    if (cyc_last) begin
                        bit_cyc <= '0;
                        ser_out <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        bit_cyc <= bit_cyc + 8'd1;
                    end
                end

                default: begin
                    bit_cyc <= '0;
                    ser_out <= 1'b1;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
